// File: rtl/gzip_output_packer.sv
// Compacts a narrow, low-aligned compressed byte stream into full OUT_W-bit words.
// Each frame closes on one tlast word; the frame byte count is reported alongside it.
module gzip_output_packer #(
  parameter int unsigned IN_W  = 64,
  parameter int unsigned OUT_W = 512,
  parameter int unsigned LEN_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_W-1:0]      s_tdata,
  input  logic [IN_W/8-1:0]    s_tkeep,
  input  logic                 s_tlast,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [OUT_W-1:0]     m_tdata,
  output logic [OUT_W/8-1:0]   m_tkeep,
  output logic                 m_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [LEN_W-1:0]     frame_len,
  output logic                 frame_len_vld,
  output logic                 err
);

  localparam int unsigned IB = IN_W / 8;
  localparam int unsigned OB = OUT_W / 8;
  localparam int unsigned WB = OB + IB;
  localparam int unsigned FW = $clog2(OB);
  localparam int unsigned NW = $clog2(IB + 1);
  localparam int unsigned TW = $clog2(WB + 1);
  localparam int unsigned SW = FW + 3;

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  state_t           state;
  logic [OUT_W-1:0] acc;
  logic [FW-1:0]    fill;
  logic [LEN_W-1:0] cnt;

  logic             slot_free;
  logic             accept;
  logic [NW-1:0]    n;
  logic [IB-1:0]    nmask;
  logic [WB*8-1:0]  in_wide;
  logic [WB*8-1:0]  comb_w;
  logic [TW-1:0]    t;
  logic             full;
  logic [FW-1:0]    left;
  logic [OB-1:0]    keep_t;
  logic [OB-1:0]    keep_f;

  assign slot_free     = !m_tvalid || m_tready;
  assign s_tready      = !rst && (state == RUN) && slot_free;
  assign accept        = s_tvalid && s_tready;
  assign frame_len_vld = m_tvalid && m_tready && m_tlast;

  // Merge the incoming beat above the bytes already held; acc bytes at or above fill are always zero.
  always_comb begin
    n       = '0;
    nmask   = '0;
    in_wide = '0;
    keep_t  = '0;
    keep_f  = '0;
    for (int i = 0; i < IB; i++) begin
      n = n + NW'(s_tkeep[i]);
    end
    for (int i = 0; i < IB; i++) begin
      nmask[i] = (NW'(i) < n);
      if (nmask[i]) begin
        in_wide[i*8 +: 8] = s_tdata[i*8 +: 8];
      end
    end
    comb_w = {IN_W'(0), acc} | (in_wide << SW'({fill, 3'b000}));
    t      = TW'(fill) + TW'(n);
    full   = (t >= TW'(OB));
    left   = full ? FW'(t - TW'(OB)) : '0;
    for (int i = 0; i < OB; i++) begin
      keep_t[i] = (TW'(i) < t);
      keep_f[i] = (FW'(i) < fill);
    end
  end

  // frame_len is captured when the closing word enters the slot, so it is valid on its handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      acc       <= '0;
      fill      <= '0;
      cnt       <= '0;
      m_tdata   <= '0;
      m_tkeep   <= '0;
      m_tlast   <= 1'b0;
      m_tvalid  <= 1'b0;
      frame_len <= '0;
      err       <= 1'b0;
    end else begin
      if (m_tvalid && m_tready) begin
        m_tvalid <= 1'b0;
      end
      if (accept && (s_tkeep != nmask)) begin
        err <= 1'b1;
      end
      case (state)
        RUN: begin
          if (accept) begin
            if (full) begin
              m_tdata  <= comb_w[OUT_W-1:0];
              m_tkeep  <= '1;
              m_tlast  <= s_tlast && (left == '0);
              m_tvalid <= 1'b1;
              acc      <= OUT_W'(comb_w[WB*8-1:OUT_W]);
              fill     <= left;
              if (s_tlast && (left == '0)) begin
                frame_len <= cnt + LEN_W'(n);
                cnt       <= '0;
              end else begin
                cnt <= cnt + LEN_W'(n);
              end
              if (s_tlast && (left != '0)) begin
                state <= FLUSH;
              end
            end else if (s_tlast) begin
              m_tdata   <= comb_w[OUT_W-1:0];
              m_tkeep   <= keep_t;
              m_tlast   <= 1'b1;
              m_tvalid  <= 1'b1;
              acc       <= '0;
              fill      <= '0;
              frame_len <= cnt + LEN_W'(n);
              cnt       <= '0;
            end else begin
              acc  <= comb_w[OUT_W-1:0];
              fill <= FW'(t);
              cnt  <= cnt + LEN_W'(n);
            end
          end
        end
        FLUSH: begin
          if (slot_free) begin
            m_tdata   <= acc;
            m_tkeep   <= keep_f;
            m_tlast   <= 1'b1;
            m_tvalid  <= 1'b1;
            acc       <= '0;
            fill      <= '0;
            frame_len <= cnt;
            cnt       <= '0;
            state     <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
